// File: rtl/axis_bram_adapter_pkg.sv
// Shared definitions for the AXIS<->BRAM adapter scheduler: default sizes, FSM encoding, counter widths.
// No timing or flow control of its own; consumed by the scheduler and its arbiter.
package axis_bram_adapter_pkg;

   localparam int BRAM_AW_DEF    = 12;
   localparam int TURNAROUND_DEF = 2;
   localparam int TIMEOUT_DEF    = 4096;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_TURN = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } sched_state_t;

   // Width able to hold 0..n-1, never narrower than one bit.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/axis_bram_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the one that was not granted last.
// Purely combinational (zero latency); the caller owns the pointer and decides when a grant is taken.
module axis_bram_rr_arb2 (
   input  logic [1:0] valid,
   input  logic       ptr,
   output logic       gnt_id,
   output logic       gnt_vld
);

   always_comb begin
      gnt_vld = |valid;
      gnt_id  = 1'b0;
      case (valid)
         2'b01:   gnt_id = 1'b0;
         2'b10:   gnt_id = 1'b1;
         2'b11:   gnt_id = ~ptr;
         default: gnt_id = 1'b0;
      endcase
   end

endmodule

// File: rtl/axis_bram_job_scheduler.sv
// Shares one AXIS<->BRAM adapter between two requesters, one job at a time, with watchdog abort.
// Latency: grant at the IDLE edge, req_ready next cycle, adapter released TURNAROUND_CYCLES later; req_valid only sampled in IDLE.
module axis_bram_job_scheduler
   import axis_bram_adapter_pkg::*;
#(
   parameter int BRAM_ADDR_LENGTH  = BRAM_AW_DEF,
   parameter int TURNAROUND_CYCLES = TURNAROUND_DEF,
   parameter int TIMEOUT_CYCLES    = TIMEOUT_DEF
) (
   input  logic                            clk,
   input  logic                            rstn,
   input  logic [1:0]                      req_valid,
   input  logic [1:0]                      req_rw,
   input  logic [2*BRAM_ADDR_LENGTH-1:0]   req_start_index,
   input  logic [2*BRAM_ADDR_LENGTH-1:0]   req_bound_index,
   output logic [1:0]                      req_ready,
   output logic [1:0]                      done_valid,
   output logic [1:0]                      done_err,
   output logic                            adp_rstn,
   output logic                            adp_rw,
   output logic [BRAM_ADDR_LENGTH-1:0]     adp_start_index,
   output logic [BRAM_ADDR_LENGTH-1:0]     adp_bound_index,
   input  logic                            adp_row_strobe,
   output logic                            busy,
   output logic                            grant_id
);

   localparam int AW     = BRAM_ADDR_LENGTH;
   localparam int ROW_W  = AW + 1;
   localparam int TURN_W = cnt_width(TURNAROUND_CYCLES);
   localparam int WD_W   = cnt_width(TIMEOUT_CYCLES);
   localparam logic [TURN_W-1:0] TURN_LAST = TURN_W'(TURNAROUND_CYCLES - 1);
   // Compared before the increment, so the abort fires on the cycle the watchdog would reach TIMEOUT_CYCLES-1.
   localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(TIMEOUT_CYCLES - 2);

   sched_state_t      state;
   logic              rr_ptr;
   logic              arb_id;
   logic              arb_vld;
   logic [AW-1:0]     sel_start;
   logic [AW-1:0]     sel_bound;
   logic              sel_rw;
   logic [ROW_W-1:0]  sel_rows;
   logic [ROW_W-1:0]  rows;
   logic [ROW_W-1:0]  row_cnt;
   logic [ROW_W-1:0]  row_nxt;
   logic [TURN_W-1:0] turn_cnt;
   logic [WD_W-1:0]   wd;

   axis_bram_rr_arb2 u_arb (
      .valid   (req_valid),
      .ptr     (rr_ptr),
      .gnt_id  (arb_id),
      .gnt_vld (arb_vld)
   );

   assign sel_start = arb_id ? req_start_index[2*AW-1:AW] : req_start_index[AW-1:0];
   assign sel_bound = arb_id ? req_bound_index[2*AW-1:AW] : req_bound_index[AW-1:0];
   assign sel_rw    = arb_id ? req_rw[1] : req_rw[0];
   // bound == start-1 wraps the AW-bit difference to all-ones, giving the full 2^AW rows.
   assign sel_rows  = {1'b0, sel_bound - sel_start} + ROW_W'(1);
   assign row_nxt   = row_cnt + ROW_W'(1);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         state           <= ST_IDLE;
         rr_ptr          <= 1'b1;
         grant_id        <= 1'b0;
         req_ready       <= '0;
         done_valid      <= '0;
         done_err        <= '0;
         adp_rstn        <= 1'b0;
         adp_rw          <= 1'b0;
         adp_start_index <= '0;
         adp_bound_index <= '0;
         busy            <= 1'b0;
         rows            <= '0;
         row_cnt         <= '0;
         turn_cnt        <= '0;
         wd              <= '0;
      end else begin
         req_ready  <= '0;
         done_valid <= '0;
         done_err   <= '0;
         unique case (state)
            ST_IDLE: begin
               if (arb_vld) begin
                  state             <= ST_TURN;
                  busy              <= 1'b1;
                  grant_id          <= arb_id;
                  rr_ptr            <= arb_id;
                  req_ready[arb_id] <= 1'b1;
                  adp_rw            <= sel_rw;
                  adp_start_index   <= sel_start;
                  adp_bound_index   <= sel_bound;
                  rows              <= sel_rows;
                  row_cnt           <= '0;
                  turn_cnt          <= '0;
                  wd                <= '0;
               end
            end
            ST_TURN: begin
               if (turn_cnt == TURN_LAST) begin
                  state    <= ST_RUN;
                  adp_rstn <= 1'b1;
               end else begin
                  turn_cnt <= turn_cnt + TURN_W'(1);
               end
            end
            ST_RUN: begin
               if (adp_row_strobe) begin
                  row_cnt <= row_nxt;
                  wd      <= '0;
                  if (row_nxt == rows) begin
                     state                <= ST_DONE;
                     adp_rstn             <= 1'b0;
                     done_valid[grant_id] <= 1'b1;
                  end
               end else if (wd == WD_LAST) begin
                  state                <= ST_DONE;
                  adp_rstn             <= 1'b0;
                  done_valid[grant_id] <= 1'b1;
                  done_err[grant_id]   <= 1'b1;
               end else begin
                  wd <= wd + WD_W'(1);
               end
            end
            ST_DONE: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axis_bram_job_scheduler.sv
// Randomized plus directed bench for axis_bram_job_scheduler, checked every cycle against a job-level model.
// Model tracks each job by its offset from the grant and its strobe / idle counts.
module tb_axis_bram_job_scheduler;

   localparam int AW = 12;
   localparam int TA = 2;
   localparam int TO = 16;

   logic          clk = 1'b0;
   logic          rstn = 1'b0;
   logic [1:0]    req_valid = '0;
   logic [1:0]    req_rw = '0;
   logic [2*AW-1:0] req_start_index = '0;
   logic [2*AW-1:0] req_bound_index = '0;
   logic [1:0]    req_ready;
   logic [1:0]    done_valid;
   logic [1:0]    done_err;
   logic          adp_rstn;
   logic          adp_rw;
   logic [AW-1:0] adp_start_index;
   logic [AW-1:0] adp_bound_index;
   logic          adp_row_strobe = 1'b0;
   logic          busy;
   logic          grant_id;

   int errors = 0;
   int checks = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   axis_bram_job_scheduler #(
      .BRAM_ADDR_LENGTH  (AW),
      .TURNAROUND_CYCLES (TA),
      .TIMEOUT_CYCLES    (TO)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .req_valid       (req_valid),
      .req_rw          (req_rw),
      .req_start_index (req_start_index),
      .req_bound_index (req_bound_index),
      .req_ready       (req_ready),
      .done_valid      (done_valid),
      .done_err        (done_err),
      .adp_rstn        (adp_rstn),
      .adp_rw          (adp_rw),
      .adp_start_index (adp_start_index),
      .adp_bound_index (adp_bound_index),
      .adp_row_strobe  (adp_row_strobe),
      .busy            (busy),
      .grant_id        (grant_id)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // ---- behavioural model: job = grant offset t, strobes counted, idle cycles counted ----
   bit          m_act = 0, m_done = 0, m_err = 0;
   int          m_g = 0, m_last = 1, m_t = 0, m_cnt = 0, m_idle = 0, m_rows = 0;
   logic        m_rw = 0;
   logic [AW-1:0] m_start = '0, m_bound = '0;
   logic [1:0]  m_ready = '0;

   always @(posedge clk) begin
      m_ready = '0;
      if (!rstn) begin
         m_act = 0; m_done = 0; m_err = 0; m_g = 0; m_last = 1;
         m_rw = 0; m_start = '0; m_bound = '0;
      end else if (m_done) begin
         m_done = 0;
         m_act  = 0;
      end else if (!m_act) begin
         if (req_valid != 2'b00) begin
            if (req_valid == 2'b11) m_g = 1 - m_last;
            else                    m_g = req_valid[1] ? 1 : 0;
            m_last  = m_g;
            m_rw    = req_rw[m_g];
            m_start = req_start_index[m_g*AW +: AW];
            m_bound = req_bound_index[m_g*AW +: AW];
            m_rows  = ((int'(m_bound) - int'(m_start) + (1 << AW)) % (1 << AW)) + 1;
            m_act = 1; m_t = 0; m_cnt = 0; m_idle = 0;
            m_ready[m_g] = 1'b1;
         end
      end else if (m_t < TA) begin
         m_t++;
      end else if (adp_row_strobe) begin
         m_cnt++;
         m_idle = 0;
         if (m_cnt == m_rows) begin m_done = 1; m_err = 0; end
      end else begin
         m_idle++;
         if (m_idle == TO - 1) begin m_done = 1; m_err = 1; end
      end
   end

   logic prev_rw = 1'b0;
   always @(negedge clk) begin
      if (chk_en) begin
         chk("req_ready",  req_ready, m_ready);
         chk("done_valid", done_valid, m_done ? (2'b01 << m_g) : 2'b00);
         chk("done_err",   done_err, (m_done && m_err) ? (2'b01 << m_g) : 2'b00);
         chk("busy",       busy, m_act);
         chk("adp_rstn",   adp_rstn, m_act && !m_done && (m_t >= TA));
         chk("grant_id",   grant_id, m_g);
         chk("adp_rw",     adp_rw, m_rw);
         chk("adp_start",  adp_start_index, m_start);
         chk("adp_bound",  adp_bound_index, m_bound);
         if (adp_rw !== prev_rw) chk("rw_change_in_reset", adp_rstn, 0);
      end
      prev_rw = adp_rw;
   end

   // ---- directed helpers ----
   task automatic issue(input int i, input bit rw, input logic [AW-1:0] s, input logic [AW-1:0] b);
      req_rw[i] = rw;
      req_start_index[i*AW +: AW] = s;
      req_bound_index[i*AW +: AW] = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_ready(input int i, input string nm, output int k);
      bit f = 0;
      k = 0;
      for (int n = 0; n < 100 && !f; n++) begin
         @(negedge clk); k++;
         if (req_ready[i]) f = 1;
      end
      chk({nm, "_ready_seen"}, f, 1);
   endtask

   task automatic wait_adp_up(input string nm, output int k);
      bit f = 0;
      k = 0;
      for (int n = 0; n < 100 && !f; n++) begin
         @(negedge clk); k++;
         if (adp_rstn) f = 1;
      end
      chk({nm, "_adp_up_seen"}, f, 1);
   endtask

   task automatic wait_done(input string nm, output int k);
      bit f = 0;
      k = 0;
      for (int n = 0; n < 200 && !f; n++) begin
         @(negedge clk); k++;
         if (done_valid != 2'b00) f = 1;
      end
      chk({nm, "_done_seen"}, f, 1);
   endtask

   // Strobe held high; counts RUN cycles (each commits one row) until done appears.
   task automatic count_rows(input string nm, output int n);
      bit f = 0;
      n = 0;
      for (int c = 0; c < 6000 && !f; c++) begin
         @(negedge clk);
         if (done_valid != 2'b00) f = 1;
         else if (adp_rstn) n++;
      end
      chk({nm, "_done_seen"}, f, 1);
   endtask

   task automatic wait_idle();
      bit f = 0;
      for (int n = 0; n < 6000 && !f; n++) begin
         @(negedge clk);
         if (!busy) f = 1;
      end
      chk("idle_reached", f, 1);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      repeat (2) @(negedge clk);
      rstn = 1'b1;
   endtask

   int k, n, extra;
   int gq[$];
   int exp_seq[4] = '{0, 1, 0, 1};
   int served[2];
   bit quiet;
   logic [AW-1:0] st;

   initial begin
      repeat (2) @(negedge clk);
      chk_en = 1'b1;
      chk("rst_busy", busy, 0);
      chk("rst_adp_rstn", adp_rstn, 0);
      chk("rst_grant_id", grant_id, 0);
      rstn = 1'b1;

      // T1: single job, 4 rows
      issue(0, 1'b1, 12'd0, 12'd3);
      wait_ready(0, "t1", k);
      chk("t1_ready_lat", k, 1);
      req_valid = 2'b00;
      wait_adp_up("t1", k);
      chk("t1_adp_up_lat", k, TA);
      for (int s = 0; s < 4; s++) begin
         adp_row_strobe = 1'b1;
         @(negedge clk);
         if (s < 3) chk("t1_no_early_done", done_valid, 2'b00);
      end
      adp_row_strobe = 1'b0;
      chk("t1_done", done_valid, 2'b01);
      chk("t1_err", done_err, 2'b00);

      // T2: both requesters, two jobs each, fresh pointer
      wait_idle();
      do_reset();
      adp_row_strobe = 1'b1;
      served = '{0, 0};
      issue(0, 1'b0, 12'd10, 12'd11);
      issue(1, 1'b1, 12'd20, 12'd21);
      for (int c = 0; c < 300 && gq.size() < 4; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++)
            if (req_ready[i]) begin
               gq.push_back(int'(grant_id));
               served[i]++;
               if (served[i] == 2) req_valid[i] = 1'b0;
            end
      end
      chk("t2_grant_count", gq.size(), 4);
      for (int j = 0; j < 4 && j < gq.size(); j++) chk("t2_grant_order", gq[j], exp_seq[j]);
      wait_idle();

      // T3: wrapping row ranges
      issue(1, 1'b0, 12'hFFE, 12'h001);
      wait_ready(1, "t3a", k);
      req_valid = 2'b00;
      count_rows("t3a", n);
      chk("t3_wrap_rows", n, 4);
      chk("t3_wrap_err", done_err, 2'b00);
      wait_idle();
      issue(0, 1'b1, 12'd5, 12'd4);
      wait_ready(0, "t3b", k);
      req_valid = 2'b00;
      count_rows("t3b", n);
      chk("t3_full_rows", n, 1 << AW);
      chk("t3_full_done", done_valid, 2'b01);
      adp_row_strobe = 1'b0;
      wait_idle();

      // T4: watchdog abort, then strobe on the last allowed cycle
      issue(0, 1'b1, 12'd0, 12'd9);
      wait_ready(0, "t4a", k);
      req_valid = 2'b00;
      wait_adp_up("t4a", k);
      adp_row_strobe = 1'b1;
      repeat (2) @(negedge clk);
      adp_row_strobe = 1'b0;
      wait_done("t4a", k);
      chk("t4_timeout_gap", k, TO - 1);
      chk("t4_timeout_err", done_err, 2'b01);
      wait_idle();
      issue(0, 1'b1, 12'd0, 12'd3);
      wait_ready(0, "t4b", k);
      req_valid = 2'b00;
      wait_adp_up("t4b", k);
      adp_row_strobe = 1'b1;
      repeat (2) @(negedge clk);
      adp_row_strobe = 1'b0;
      quiet = 1;
      repeat (TO - 2) begin
         @(negedge clk);
         if (done_valid != 2'b00) quiet = 0;
      end
      chk("t4_no_abort", quiet, 1);
      adp_row_strobe = 1'b1;
      repeat (2) @(negedge clk);
      adp_row_strobe = 1'b0;
      chk("t4_late_done", done_valid, 2'b01);
      chk("t4_late_err", done_err, 2'b00);
      wait_idle();

      // T5: reset mid-run, then a normal job
      issue(1, 1'b1, 12'd0, 12'd20);
      wait_ready(1, "t5a", k);
      req_valid = 2'b00;
      wait_adp_up("t5a", k);
      adp_row_strobe = 1'b1;
      repeat (2) @(negedge clk);
      rstn = 1'b0;
      @(negedge clk);
      chk("t5_rst_ready", req_ready, 2'b00);
      chk("t5_rst_done", done_valid, 2'b00);
      chk("t5_rst_adp_rstn", adp_rstn, 0);
      chk("t5_rst_rw", adp_rw, 0);
      chk("t5_rst_start", adp_start_index, 0);
      chk("t5_rst_busy", busy, 0);
      rstn = 1'b1;
      issue(0, 1'b0, 12'd7, 12'd9);
      wait_ready(0, "t5b", k);
      chk("t5_ready_lat", k, 1);
      req_valid = 2'b00;
      count_rows("t5b", n);
      chk("t5_rows", n, 3);
      wait_idle();

      // T6: valid held through a job, direction flipped for the next one
      issue(0, 1'b1, 12'd0, 12'd1);
      wait_ready(0, "t6a", k);
      req_rw[0] = 1'b0;
      extra = 0;
      for (int c = 0; c < 50 && done_valid == 2'b00; c++) begin
         @(negedge clk);
         if (req_ready[0]) extra++;
      end
      chk("t6_no_reaccept", extra, 0);
      wait_ready(0, "t6b", k);
      chk("t6_regrant_lat", k, 2);
      chk("t6_new_rw", adp_rw, 0);
      req_valid = 2'b00;
      wait_idle();
      adp_row_strobe = 1'b0;

      // Random traffic against the model
      for (int c = 0; c < 5000; c++) begin
         @(negedge clk);
         for (int i = 0; i < 2; i++) begin
            if (req_valid[i]) begin
               if (req_ready[i] || $urandom_range(0, 31) == 0) req_valid[i] = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
               st = AW'($urandom);
               issue(i, 1'($urandom), st, st + AW'($urandom_range(0, 9)));
            end
         end
         if ((c % 500) < 40) adp_row_strobe = 1'b0;
         else                adp_row_strobe = ($urandom_range(0, 9) < 6);
         rstn = ($urandom_range(0, 1499) != 0);
      end
      rstn = 1'b1;
      req_valid = 2'b00;
      adp_row_strobe = 1'b1;
      wait_idle();
      @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
